// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: redirect input, instruction-memory request/response
// channel and the decode-side {pc, instr} handshake.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   mem_req_valid;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic                   mem_req_ready;
  logic                   mem_resp_valid;
  logic [INSTR_WIDTH-1:0] mem_resp_data;
  logic                   out_valid;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic                   out_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
           mem_resp_data, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
           mem_resp_data, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with credit-limited requests, an in-order
// instruction queue toward decode, and redirect flush with stale-response drop.
module fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0]  fetchPc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          dropCnt;
  logic [CW-1:0]          qCount;
  logic [PW-1:0]          qRd;
  logic [PW-1:0]          qWr;
  logic [PW-1:0]          pfRd;
  logic [PW-1:0]          pfWr;
  logic [ADDR_WIDTH-1:0]  qPc    [DEPTH];
  logic [INSTR_WIDTH-1:0] qInstr [DEPTH];
  logic [ADDR_WIDTH-1:0]  pfPc   [DEPTH];

  logic [CW+1:0] creditUsed;
  logic          creditOk;
  logic          reqValid;
  logic          reqFire;
  logic          respPush;
  logic          respDrop;
  logic          outValid;
  logic          pop;
  logic          qNotEmpty;

  // Stale drops keep holding credits until their responses come back.
  assign creditUsed = {2'b00, qCount} + {2'b00, outstanding} + {2'b00, dropCnt};
  assign creditOk   = creditUsed < (CW+2)'(DEPTH);

  // Gating on reset keeps the request channel quiet while the memory is held in reset.
  assign reqValid  = !reset && !bus.redirect_valid && creditOk;
  assign reqFire   = reqValid && bus.mem_req_ready;
  assign respPush  = bus.mem_resp_valid && (dropCnt == '0);
  assign respDrop  = bus.mem_resp_valid && (dropCnt != '0);
  assign qNotEmpty = (qCount != '0);
  assign outValid  = qNotEmpty && !bus.redirect_valid;
  assign pop       = outValid && bus.out_ready;

  assign bus.mem_req_valid = reqValid;
  assign bus.mem_req_addr  = fetchPc;
  assign bus.out_valid     = outValid;
  assign bus.out_pc        = qNotEmpty ? qPc[qRd]    : '0;
  assign bus.out_instr     = qNotEmpty ? qInstr[qRd] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      qCount      <= '0;
      qRd         <= '0;
      qWr         <= '0;
      pfRd        <= '0;
      pfWr        <= '0;
    end else if (bus.redirect_valid) begin
      // Everything in flight becomes stale, including any response landing now.
      fetchPc     <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      dropCnt     <= dropCnt + outstanding - CW'(bus.mem_resp_valid);
      outstanding <= '0;
      qCount      <= '0;
      qRd         <= '0;
      qWr         <= '0;
      pfRd        <= '0;
      pfWr        <= '0;
    end else begin
      if (reqFire) begin
        fetchPc <= fetchPc + ADDR_WIDTH'(4);
        pfWr    <= pfWr + PW'(1);
      end
      if (respPush) begin
        qWr  <= qWr + PW'(1);
        pfRd <= pfRd + PW'(1);
      end
      if (respDrop) begin
        dropCnt <= dropCnt - CW'(1);
      end
      if (pop) begin
        qRd <= qRd + PW'(1);
      end
      outstanding <= outstanding + CW'(reqFire) - CW'(respPush);
      qCount      <= qCount + CW'(respPush) - CW'(pop);
    end
  end

  // Storage is not reset; the pointers and count decide what is meaningful.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      pfPc[pfWr] <= fetchPc;
    end
    if (respPush) begin
      qPc[qWr]    <= pfPc[pfRd];
      qInstr[qWr] <= bus.mem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model, reference queue of fetched
// {pc, instr} pairs, directed vector tables and randomized traffic.
module tb_fetch_queue;
  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fq();

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (fq)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    bit          rdv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ordy;
    bit          eReqV;
    logic [31:0] eAddr;
    bit          eOutV;
    logic [31:0] eOutPc;
  } vec_t;

  memReq_t     memQ[$];
  entry_t      arrived[$];
  vec_t        vt[$];
  int          cyc, lat, respPct, nCmp, nFail;
  logic [31:0] modelPc;
  bit          armed, rstState;
  logic        obsReqValid, obsOutValid;
  logic [31:0] obsReqAddr, obsOutPc, obsOutInstr;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, play the memory, compare against the model, advance.
  task automatic step(input bit rst, input bit rdv, input logic [31:0] rpc,
                      input bit rdy, input bit ordy);
    bit          respNow, expReqValid, expOutValid;
    logic [31:0] respData;
    memReq_t     head, nreq;
    entry_t      e;
    reset             = rst;
    fq.redirect_valid = rdv;
    fq.redirect_pc    = rpc;
    fq.mem_req_ready  = rdy;
    fq.out_ready      = ordy;
    respNow  = 1'b0;
    respData = $urandom();
    if (!rst && memQ.size() != 0) begin
      if (memQ[0].due <= cyc && $urandom_range(0, 99) < respPct) begin
        respNow  = 1'b1;
        respData = memFn(memQ[0].addr);
      end
    end
    fq.mem_resp_valid = respNow;
    fq.mem_resp_data  = respData;
    #1;
    obsReqValid = fq.mem_req_valid;
    obsReqAddr  = fq.mem_req_addr;
    obsOutValid = fq.out_valid;
    obsOutPc    = fq.out_pc;
    obsOutInstr = fq.out_instr;
    expReqValid = !rst && !rdv && (memQ.size() + arrived.size() < DEPTH);
    expOutValid = !rdv && (arrived.size() != 0);
    if (armed) begin
      check("mem_req_valid", {31'd0, obsReqValid}, {31'd0, expReqValid});
      check("mem_req_addr", obsReqAddr, modelPc);
      check("out_valid", {31'd0, obsOutValid}, {31'd0, expOutValid});
      if (expOutValid) begin
        check("out_pc", obsOutPc, arrived[0].pc);
        check("out_instr", obsOutInstr, arrived[0].instr);
      end else if (rstState) begin
        check("reset_out_pc", obsOutPc, 32'h0);
        check("reset_out_instr", obsOutInstr, 32'h0);
      end
    end
    if (rst) begin
      memQ.delete();
      arrived.delete();
      modelPc = RPC;
    end else begin
      if (expOutValid && ordy) void'(arrived.pop_front());
      if (respNow) begin
        head = memQ.pop_front();
        if (!head.stale && !rdv) begin
          e.pc    = head.addr;
          e.instr = respData;
          arrived.push_back(e);
        end
      end
      if (rdv) begin
        arrived.delete();
        foreach (memQ[i]) memQ[i].stale = 1'b1;
        modelPc = {rpc[31:2], 2'b00};
      end else if (expReqValid && rdy) begin
        modelPc = modelPc + 32'd4;
      end
      if (fq.mem_req_valid && rdy) begin
        nreq.addr  = fq.mem_req_addr;
        nreq.due   = cyc + lat;
        nreq.stale = 1'b0;
        memQ.push_back(nreq);
      end
      if (armed) check("inflight_bound", {31'd0, memQ.size() <= DEPTH}, 32'd1);
    end
    rstState = rst;
    if (rst) armed = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic doReset();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  function automatic vec_t mk(input bit ordy, input bit eReqV, input logic [31:0] eAddr,
                              input bit eOutV, input logic [31:0] eOutPc);
    vec_t v;
    v.rdv = 1'b0; v.rpc = 32'h0; v.rdy = 1'b1; v.ordy = ordy;
    v.eReqV = eReqV; v.eAddr = eAddr; v.eOutV = eOutV; v.eOutPc = eOutPc;
    return v;
  endfunction

  task automatic runTable(input string tag);
    foreach (vt[i]) begin
      step(1'b0, vt[i].rdv, vt[i].rpc, vt[i].rdy, vt[i].ordy);
      check({tag, "_req_valid"}, {31'd0, obsReqValid}, {31'd0, vt[i].eReqV});
      check({tag, "_req_addr"}, obsReqAddr, vt[i].eAddr);
      check({tag, "_out_valid"}, {31'd0, obsOutValid}, {31'd0, vt[i].eOutV});
      if (vt[i].eOutV) begin
        check({tag, "_out_pc"}, obsOutPc, vt[i].eOutPc);
        check({tag, "_out_instr"}, obsOutInstr, memFn(vt[i].eOutPc));
      end
    end
    vt.delete();
  endtask

  task automatic waitOutPc(input string tag, input logic [31:0] expPc);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (obsOutValid) begin
        seen = 1'b1;
        check(tag, obsOutPc, expPc);
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    nCmp = 0; nFail = 0; cyc = 0; lat = 1; respPct = 100;
    modelPc = RPC; armed = 1'b0; rstState = 1'b0;
    fq.redirect_valid = 1'b0; fq.redirect_pc = '0; fq.mem_req_ready = 1'b0;
    fq.mem_resp_valid = 1'b0; fq.mem_resp_data = '0; fq.out_ready = 1'b0;
    #1;
    doReset();
    check("reset_req_valid", {31'd0, obsReqValid}, 32'd0);
    check("reset_out_valid", {31'd0, obsOutValid}, 32'd0);

    // Reset release, 1-cycle memory, decode always ready
    vt.push_back(mk(1, 1, 32'h00, 0, 32'h0));
    vt.push_back(mk(1, 1, 32'h04, 0, 32'h0));
    vt.push_back(mk(1, 1, 32'h08, 1, 32'h00));
    vt.push_back(mk(1, 1, 32'h0C, 1, 32'h04));
    vt.push_back(mk(1, 1, 32'h10, 1, 32'h08));
    vt.push_back(mk(1, 1, 32'h14, 1, 32'h0C));
    runTable("stream");

    // Decode stalled: credits run out, one pop frees exactly one request
    doReset();
    vt.push_back(mk(0, 1, 32'h00, 0, 32'h0));
    vt.push_back(mk(0, 1, 32'h04, 0, 32'h0));
    vt.push_back(mk(0, 1, 32'h08, 1, 32'h0));
    vt.push_back(mk(0, 1, 32'h0C, 1, 32'h0));
    vt.push_back(mk(0, 0, 32'h10, 1, 32'h0));
    vt.push_back(mk(0, 0, 32'h10, 1, 32'h0));
    vt.push_back(mk(1, 0, 32'h10, 1, 32'h0));
    vt.push_back(mk(0, 1, 32'h10, 1, 32'h4));
    vt.push_back(mk(0, 0, 32'h14, 1, 32'h4));
    vt.push_back(mk(0, 0, 32'h14, 1, 32'h4));
    runTable("stall");

    // Redirect with three fetches in flight
    doReset();
    lat = 4;
    idle(3);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
    check("redir_req_gate", {31'd0, obsReqValid}, 32'd0);
    check("redir_out_gate", {31'd0, obsOutValid}, 32'd0);
    idle(1);
    check("redir_next_valid", {31'd0, obsReqValid}, 32'd1);
    check("redir_next_addr", obsReqAddr, 32'h0000_0100);
    waitOutPc("redir_first_out", 32'h0000_0100);

    // Redirect coinciding with a response and a ready decode
    doReset();
    lat = 2;
    idle(3);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    check("redir_resp_seen", {31'd0, fq.mem_resp_valid}, 32'd1);
    check("redir_resp_nopop", {31'd0, obsOutValid}, 32'd0);
    idle(1);
    check("redir2_next_addr", obsReqAddr, 32'h0000_0200);
    waitOutPc("redir2_first_out", 32'h0000_0200);

    // Fetch PC wraps at the top of the address space
    doReset();
    lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    idle(1);
    check("wrap_addr_top", obsReqAddr, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_addr_zero", obsReqAddr, 32'h0000_0000);
    waitOutPc("wrap_first_out", 32'hFFFF_FFFC);
    idle(1);
    check("wrap_second_out", obsOutPc, 32'h0000_0000);

    // Sustained one-per-cycle delivery at 2-cycle memory latency
    doReset();
    lat = 2;
    idle(6);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      check("throughput_out_valid", {31'd0, obsOutValid}, 32'd1);
    end

    // Reset mid-stream with queued entries and requests in flight
    doReset();
    lat = 6;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_queue_held", {31'd0, obsOutValid}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_rst_out_valid", {31'd0, obsOutValid}, 32'd0);
    check("mid_rst_req_valid", {31'd0, obsReqValid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mid_rel_req_valid", {31'd0, obsReqValid}, 32'd1);
    check("mid_rel_req_addr", obsReqAddr, RPC);

    // Randomized traffic against the reference model
    for (int ph = 0; ph < 6; ph++) begin
      lat     = $urandom_range(1, 6);
      respPct = $urandom_range(40, 100);
      for (int i = 0; i < 400; i++) begin
        logic [31:0] rpc;
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 4, rpc,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
